// File: rtl/filter_ctrl_if.sv
// Byte-stream and configuration bundle between the pixel packer, the
// scanline filter scheduler and the deflate stage.
interface filter_ctrl_if #(
    parameter int WID_WD = 13,
    parameter int HGT_WD = 16
);
    logic              start_i;
    logic [WID_WD-1:0] cfg_wid_i;
    logic [HGT_WD-1:0] cfg_hgt_i;
    logic [3:0]        cfg_bpp_i;
    logic [2:0]        cfg_typ_i;
    logic [7:0]        dat_i;
    logic              val_i;
    logic              rdy_o;
    logic [7:0]        dat_o;
    logic              val_o;
    logic              rdy_i;
    logic              lst_o;
    logic              done_o;

    // Driver of raw bytes / consumer of filtered bytes.
    modport master (
        output start_i, cfg_wid_i, cfg_hgt_i, cfg_bpp_i, cfg_typ_i,
        output dat_i, val_i, rdy_i,
        input  rdy_o, dat_o, val_o, lst_o, done_o
    );

    // The filter scheduler itself.
    modport slave (
        input  start_i, cfg_wid_i, cfg_hgt_i, cfg_bpp_i, cfg_typ_i,
        input  dat_i, val_i, rdy_i,
        output rdy_o, dat_o, val_o, lst_o, done_o
    );
endinterface

// File: rtl/filter_ctrl.sv
// PNG scanline filter scheduler: emits a filter-type byte per row followed by
// the row's filtered bytes. Keeps one previous row plus left/up pixel history.

// Paeth predictor: picks whichever of a, b, c is closest to a+b-c
// (ties resolved a, then b, then c).
module filter_paeth #(
    parameter int DATA_WD = 8
) (
    input  logic [DATA_WD-1:0] a,
    input  logic [DATA_WD-1:0] b,
    input  logic [DATA_WD-1:0] c,
    output logic [DATA_WD-1:0] pred
);
    localparam int SW = DATA_WD + 2;

    logic signed [SW-1:0] p, da, db, dc;
    logic signed [SW-1:0] pa, pb, pc;

    // Distance of the linear estimate to each neighbour, then the selection.
    always_comb begin
        p    = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});
        da   = p - $signed({2'b00, a});
        db   = p - $signed({2'b00, b});
        dc   = p - $signed({2'b00, c});
        pa   = (da < 0) ? -da : da;
        pb   = (db < 0) ? -db : db;
        pc   = (dc < 0) ? -dc : dc;
        if (pa <= pb && pa <= pc) pred = a;
        else if (pb <= pc)        pred = b;
        else                      pred = c;
    end
endmodule

module filter_ctrl #(
    parameter int WID_MAX = 4096,
    parameter int WID_WD  = 13,
    parameter int HGT_WD  = 16,
    parameter int BPP_MAX = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    filter_ctrl_if.slave bus
);
    localparam int LB_AW  = $clog2(WID_MAX);
    localparam int BPP_AW = $clog2(BPP_MAX);

    typedef enum logic [1:0] {IDLE, TYPE, DATA, DONE} state_t;

    state_t            state, state_nxt;
    logic [WID_WD-1:0] wid, col;
    logic [HGT_WD-1:0] hgt, row;
    logic [3:0]        bpp;
    logic [2:0]        typ;
    logic              typ_out;   // type byte of the current row already loaded
    logic [7:0]        out_dat;
    logic              out_val, out_lst, done_q;
    logic [7:0]        left_hist [BPP_MAX];
    logic [7:0]        up_hist   [BPP_MAX];
    logic [7:0]        line_buf  [WID_MAX];

    logic              rdy, xfer, out_free, last_col, last_row;
    logic              enter_type, load_type, leave_type, finish;
    logic [BPP_AW-1:0] bpp_idx;
    logic [7:0]        op_x, op_a, op_b, op_c, paeth, filt;
    logic [8:0]        sum_ab;

    assign out_free = !out_val || bus.rdy_i;
    assign last_col = (col == wid - WID_WD'(1));
    assign last_row = (row == hgt - HGT_WD'(1));
    assign bpp_idx  = BPP_AW'(bpp - 4'd1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt  = state;
        rdy        = 1'b0;
        enter_type = 1'b0;
        load_type  = 1'b0;
        leave_type = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (bus.start_i) begin
                state_nxt  = TYPE;
                enter_type = 1'b1;
            end
            TYPE: if (out_free) begin
                if (!typ_out) begin
                    load_type = 1'b1;
                end else begin
                    leave_type = 1'b1;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                rdy = out_free;
                if (bus.val_i && rdy && last_col) begin
                    if (last_row) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt  = TYPE;
                        enter_type = 1'b1;
                    end
                end
            end
            DONE: if (out_free) begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        xfer = bus.val_i && rdy;
    end

    // Filter operands and the selected filter result for the incoming byte.
    always_comb begin
        op_x   = bus.dat_i;
        op_a   = left_hist[bpp_idx];
        op_c   = up_hist[bpp_idx];
        op_b   = (row == '0) ? 8'd0 : line_buf[col[LB_AW-1:0]];
        sum_ab = {1'b0, op_a} + {1'b0, op_b};
        case (typ)
            3'd1:    filt = op_x - op_a;
            3'd2:    filt = op_x - op_b;
            3'd3:    filt = op_x - sum_ab[8:1];
            3'd4:    filt = op_x - paeth;
            default: filt = op_x;
        endcase
    end

    filter_paeth #(.DATA_WD(8)) u_paeth (
        .a    (op_a),
        .b    (op_b),
        .c    (op_c),
        .pred (paeth)
    );

    // Previous-row storage: raw byte written after its old value was read as b.
    // NOTE: the line buffer is deliberately not reset; row 0 masks its contents.
    always_ff @(posedge clk_i) begin
        if (xfer) line_buf[col[LB_AW-1:0]] <= bus.dat_i;
    end

    // Frame configuration, counters, histories and the output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wid     <= '0;
            hgt     <= '0;
            bpp     <= '0;
            typ     <= '0;
            row     <= '0;
            col     <= '0;
            typ_out <= 1'b0;
            out_dat <= '0;
            out_val <= 1'b0;
            out_lst <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < BPP_MAX; k++) begin
                left_hist[k] <= '0;
                up_hist[k]   <= '0;
            end
        end else begin
            done_q <= finish;
            if (state == IDLE && bus.start_i) begin
                wid <= bus.cfg_wid_i;
                hgt <= bus.cfg_hgt_i;
                bpp <= bus.cfg_bpp_i;
                row <= '0;
            end
            if (xfer) begin
                col          <= col + WID_WD'(1);
                left_hist[0] <= bus.dat_i;
                up_hist[0]   <= op_b;
                for (int k = 1; k < BPP_MAX; k++) begin
                    left_hist[k] <= left_hist[k-1];
                    up_hist[k]   <= up_hist[k-1];
                end
            end
            // Row boundary overrides the per-byte updates above.
            if (enter_type) begin
                typ     <= (bus.cfg_typ_i > 3'd4) ? 3'd0 : bus.cfg_typ_i;
                col     <= '0;
                typ_out <= 1'b0;
                if (state == DATA) row <= row + HGT_WD'(1);
                for (int k = 0; k < BPP_MAX; k++) begin
                    left_hist[k] <= '0;
                    up_hist[k]   <= '0;
                end
            end
            if (load_type) begin
                out_dat <= {5'd0, typ};
                out_val <= 1'b1;
                out_lst <= 1'b0;
                typ_out <= 1'b1;
            end else if (leave_type) begin
                out_val <= 1'b0;
            end else if (xfer) begin
                out_dat <= filt;
                out_val <= 1'b1;
                out_lst <= last_col;
            end else if (bus.rdy_i) begin
                out_val <= 1'b0;
            end
        end
    end

    assign bus.rdy_o  = rdy;
    assign bus.dat_o  = out_dat;
    assign bus.val_o  = out_val;
    assign bus.lst_o  = out_lst;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_filter_ctrl.sv
// Self-checking bench for filter_ctrl: directed frames plus randomized frames
// and stalls, compared against a row/column reference model.
module tb_filter_ctrl;
    localparam int WID_WD = 13;
    localparam int HGT_WD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filter_ctrl_if #(.WID_WD(WID_WD), .HGT_WD(HGT_WD)) bus ();

    filter_ctrl #(.WID_MAX(4096), .WID_WD(WID_WD), .HGT_WD(HGT_WD), .BPP_MAX(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;
    int raw_q[$];   // raw bytes of the frame, row-major
    int typ_q[$];   // requested filter type per row
    int exp_q[$];   // expected outputs: bit 8 = last-of-row flag, bits 7:0 = byte
    int got_q[$];   // captured outputs, same encoding
    int dones;
    int unstable;

    function automatic int paeth_ref(int a, int b, int c);
        int p, pa, pb, pc;
        p  = a + b - c;
        pa = (p > a) ? p - a : a - p;
        pb = (p > b) ? p - b : b - p;
        pc = (p > c) ? p - c : c - p;
        if (pa <= pb && pa <= pc) return a;
        if (pb <= pc) return b;
        return c;
    endfunction

    // Expected stream computed directly from the filter definitions.
    function automatic void build_expected(int wid, int hgt, int bpp);
        exp_q.delete();
        for (int r = 0; r < hgt; r++) begin
            int t;
            t = (typ_q[r] > 4) ? 0 : typ_q[r];
            exp_q.push_back(t);
            for (int i = 0; i < wid; i++) begin
                int x, a, b, c, pred, v;
                x = raw_q[r*wid + i];
                a = (i >= bpp) ? raw_q[r*wid + i - bpp] : 0;
                b = (r > 0) ? raw_q[(r-1)*wid + i] : 0;
                c = (r > 0 && i >= bpp) ? raw_q[(r-1)*wid + i - bpp] : 0;
                case (t)
                    1: pred = a;
                    2: pred = b;
                    3: pred = (a + b) / 2;
                    4: pred = paeth_ref(a, b, c);
                    default: pred = 0;
                endcase
                v = (x - pred) & 255;
                if (i == wid - 1) v = v | 256;
                exp_q.push_back(v);
            end
        end
    endfunction

    // Runs one frame from raw_q/typ_q with the given valid/ready percentages,
    // capturing every popped byte, done pulses and hold-stability violations.
    task automatic run_frame(input int wid, input int hgt, input int bpp,
                             input int p_val, input int p_rdy);
        int idx, total, cyc, nxt_row;
        bit held, in_x;
        int held_v;
        got_q.delete();
        dones = 0; unstable = 0; idx = 0; cyc = 0; held = 0;
        total = wid * hgt;
        @(posedge clk); #1;
        bus.cfg_wid_i = WID_WD'(wid);
        bus.cfg_hgt_i = HGT_WD'(hgt);
        bus.cfg_bpp_i = 4'(bpp);
        bus.cfg_typ_i = 3'(typ_q[0]);
        bus.start_i   = 1'b1;
        bus.val_i     = 1'b0;
        bus.rdy_i     = 1'b0;
        @(posedge clk); #1;
        while (dones == 0 && cyc < 5000) begin
            nxt_row = idx / wid + 1;
            if (nxt_row > hgt - 1) nxt_row = hgt - 1;
            bus.cfg_typ_i = 3'(typ_q[nxt_row]);
            bus.start_i   = (idx < total) && ($urandom_range(99) < 5);
            bus.val_i     = (idx < total) && ($urandom_range(99) < p_val);
            bus.dat_i     = (idx < total) ? 8'(raw_q[idx]) : 8'd0;
            bus.rdy_i     = ($urandom_range(99) < p_rdy);
            @(negedge clk);
            if (held && (!bus.val_o || int'({bus.lst_o, bus.dat_o}) != held_v)) unstable++;
            held   = bus.val_o && !bus.rdy_i;
            held_v = int'({bus.lst_o, bus.dat_o});
            if (bus.val_o && bus.rdy_i) got_q.push_back(int'({bus.lst_o, bus.dat_o}));
            in_x = bus.val_i && bus.rdy_o;
            if (bus.done_o) dones++;
            @(posedge clk); #1;
            if (in_x) idx++;
            cyc++;
        end
        bus.start_i = 1'b0;
        bus.val_i   = 1'b0;
        bus.rdy_i   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done_o) dones++;
            if (bus.val_o) got_q.push_back(int'({bus.lst_o, bus.dat_o}));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.val_i = 1'b1; bus.rdy_i = 1'b1; bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.val_o !== 1'b0) begin bad_cnt++; $display("FAIL reset_val_o: got %b want 0", bus.val_o); end
        total_cnt++;
        if (bus.rdy_o !== 1'b0) begin bad_cnt++; $display("FAIL reset_rdy_o: got %b want 0", bus.rdy_o); end
        total_cnt++;
        if (bus.lst_o !== 1'b0) begin bad_cnt++; $display("FAIL reset_lst_o: got %b want 0", bus.lst_o); end
        total_cnt++;
        if (bus.done_o !== 1'b0) begin bad_cnt++; $display("FAIL reset_done_o: got %b want 0", bus.done_o); end
        total_cnt++;
        if (bus.dat_o !== 8'd0) begin bad_cnt++; $display("FAIL reset_dat_o: got %0h want 0", bus.dat_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.val_i = 1'b0;
    endtask

    task automatic test_none();
        raw_q = '{10, 20, 30, 40};
        typ_q = '{0};
        exp_q = '{'h000, 'h00A, 'h014, 'h01E, 'h128};
        run_frame(4, 1, 1, 100, 100);
        total_cnt++;
        if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL none_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL none_byte[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        total_cnt++;
        if (dones !== 1) begin bad_cnt++; $display("FAIL none_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_sub();
        raw_q = '{10, 20, 30, 250};
        typ_q = '{1};
        exp_q = '{'h001, 'h00A, 'h00A, 'h00A, 'h1DC};
        run_frame(4, 1, 1, 100, 100);
        total_cnt++;
        if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL sub_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL sub_byte[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        total_cnt++;
        if (dones !== 1) begin bad_cnt++; $display("FAIL sub_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_up();
        raw_q = '{5, 6, 7, 4, 6, 9};
        typ_q = '{0, 2};
        exp_q = '{'h000, 'h005, 'h006, 'h107, 'h002, 'h0FF, 'h000, 'h102};
        run_frame(3, 2, 1, 100, 100);
        total_cnt++;
        if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL up_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL up_byte[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        total_cnt++;
        if (dones !== 1) begin bad_cnt++; $display("FAIL up_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_avg_paeth();
        for (int t = 3; t <= 4; t++) begin
            raw_q.delete();
            for (int i = 0; i < 12; i++) raw_q.push_back(int'($urandom_range(255)));
            typ_q = '{t, t};
            build_expected(6, 2, 3);
            run_frame(6, 2, 3, 100, 100);
            total_cnt++;
            if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL avgpaeth%0d_len: got %0d want %0d", t, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total_cnt++;
                if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL avgpaeth%0d_byte[%0d]: got %0h want %0h", t, i, got_q[i], exp_q[i]); end
            end
            total_cnt++;
            if (dones !== 1) begin bad_cnt++; $display("FAIL avgpaeth%0d_done: got %0d pulses want 1", t, dones); end
        end
    endtask

    // Reuses the last Paeth frame with heavy stalls on both sides.
    task automatic test_stall();
        build_expected(6, 2, 3);
        run_frame(6, 2, 3, 55, 45);
        total_cnt++;
        if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL stall_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL stall_byte[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        total_cnt++;
        if (unstable !== 0) begin bad_cnt++; $display("FAIL stall_hold: got %0d unstable cycles want 0", unstable); end
        total_cnt++;
        if (dones !== 1) begin bad_cnt++; $display("FAIL stall_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        bus.cfg_wid_i = WID_WD'(6);
        bus.cfg_hgt_i = HGT_WD'(2);
        bus.cfg_bpp_i = 4'd2;
        bus.cfg_typ_i = 3'd1;
        bus.start_i   = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.val_i   = 1'b1;
        bus.rdy_i   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.dat_i = 8'(i * 37 + 3);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.val_o !== 1'b0 || bus.rdy_o !== 1'b0 || bus.lst_o !== 1'b0 || bus.dat_o !== 8'd0)
        begin
            bad_cnt++;
            $display("FAIL midrst_outputs: got val=%b rdy=%b lst=%b dat=%0h want all 0",
                     bus.val_o, bus.rdy_o, bus.lst_o, bus.dat_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.val_i = 1'b0;
        raw_q = '{10, 20, 30, 40};
        typ_q = '{6};
        exp_q = '{'h000, 'h00A, 'h014, 'h01E, 'h128};
        run_frame(4, 1, 1, 100, 100);
        total_cnt++;
        if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL midrst_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL midrst_byte[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        total_cnt++;
        if (dones !== 1) begin bad_cnt++; $display("FAIL midrst_done: got %0d pulses want 1", dones); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int wid, hgt, bpp, pv, pr;
            wid = $urandom_range(20, 1);
            hgt = $urandom_range(4, 1);
            bpp = $urandom_range(8, 1);
            pv  = $urandom_range(100, 40);
            pr  = $urandom_range(100, 40);
            raw_q.delete();
            typ_q.delete();
            for (int i = 0; i < wid * hgt; i++) raw_q.push_back(int'($urandom_range(255)));
            for (int r = 0; r < hgt; r++) typ_q.push_back(int'($urandom_range(7)));
            build_expected(wid, hgt, bpp);
            run_frame(wid, hgt, bpp, pv, pr);
            total_cnt++;
            if (got_q.size() !== exp_q.size()) begin bad_cnt++; $display("FAIL rand%0d_len: got %0d want %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total_cnt++;
                if (got_q[i] !== exp_q[i]) begin bad_cnt++; $display("FAIL rand%0d_byte[%0d]: got %0h want %0h", f, i, got_q[i], exp_q[i]); end
            end
            total_cnt++;
            if (unstable !== 0) begin bad_cnt++; $display("FAIL rand%0d_hold: got %0d unstable cycles want 0", f, unstable); end
            total_cnt++;
            if (dones !== 1) begin bad_cnt++; $display("FAIL rand%0d_done: got %0d pulses want 1", f, dones); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.cfg_wid_i = '0;
        bus.cfg_hgt_i = '0;
        bus.cfg_bpp_i = '0;
        bus.cfg_typ_i = '0;
        bus.dat_i     = '0;
        bus.val_i     = 1'b0;
        bus.rdy_i     = 1'b0;
        test_reset();
        test_none();
        test_sub();
        test_up();
        test_avg_paeth();
        test_stall();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
